// File: rtl/hex_uart_pkg.sv
// ---------------------------------------------------------------------------
// hex_uart_pkg
// Shared constants, FSM state encoding and character selection helper for
// the hex-string UART transmitter (hex_string_uart_tx and uart_tx_byte).
// ---------------------------------------------------------------------------
package hex_uart_pkg;

    localparam logic [7:0] ASCII_CR        = 8'h0D;
    localparam logic [7:0] ASCII_LF        = 8'h0A;
    localparam int         UART_FRAME_BITS = 10;   // start + 8 data + stop

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_FINISH = 3'd4
    } hex_uart_state_e;

    // Character idx of the message: 0..7 come from the string (char0 in the
    // top byte), 8 and 9 are the CR LF trailer.
    function automatic logic [7:0] pick_char(input logic [63:0] str,
                                             input logic [3:0]  idx);
        logic [5:0] sh;
        sh = {~idx[2:0], 3'b000};           // (7 - idx) * 8
        case (idx)
            4'd8:    pick_char = ASCII_CR;
            4'd9:    pick_char = ASCII_LF;
            default: pick_char = str[sh +: 8];
        endcase
    endfunction

endpackage

// File: rtl/hex_string_uart_tx_if.sv
// ---------------------------------------------------------------------------
// hex_string_uart_tx_if
// Valid/ready handshake carrying one 8-character ASCII hex string.
//   str_in    : 64-bit string, char0 in [63:56]
//   str_valid : source holds high until accepted
//   str_ready : sink idle and able to accept
// ---------------------------------------------------------------------------
interface hex_string_uart_tx_if;

    logic [63:0] str_in;
    logic        str_valid;
    logic        str_ready;

    modport master (output str_in, output str_valid, input  str_ready);
    modport slave  (input  str_in, input  str_valid, output str_ready);

endinterface

// File: rtl/hex_string_uart_tx_byte.sv
// ---------------------------------------------------------------------------
// uart_tx_byte
// Single-byte 8N1 serializer. Owns the baud and bit counters.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_start       : load i_data and begin a frame (honoured when idle or in
//                   the last stop-bit cycle, so frames can run gapless)
//   i_data        : byte to send, LSB first
//   o_tx          : registered serial output, idle high
//   o_byte_done   : high during the final cycle of the stop bit
//   o_phase       : ST_IDLE / ST_START / ST_DATA / ST_STOP
// ---------------------------------------------------------------------------
module uart_tx_byte
    import hex_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [7:0]      i_data,
    output logic            o_tx,
    output logic            o_byte_done,
    output hex_uart_state_e o_phase
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    hex_uart_state_e   r_phase;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;     // bit currently on the line sits in [0]
    logic              r_tx;

    logic w_baud_end;
    logic w_can_load;

    assign w_baud_end  = (r_phase != ST_IDLE) && (r_baud == BAUD_LAST);
    assign o_byte_done = w_baud_end && (r_phase == ST_STOP);
    assign w_can_load  = (r_phase == ST_IDLE) || o_byte_done;
    assign o_tx        = r_tx;
    assign o_phase     = r_phase;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else if (i_start && w_can_load) begin
            r_phase <= ST_START;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= i_data;
            r_tx    <= 1'b0;
        end else if (r_phase != ST_IDLE) begin
            if (w_baud_end) begin
                r_baud <= '0;
                case (r_phase)
                    ST_START: begin
                        r_phase <= ST_DATA;
                        r_tx    <= r_shift[0];
                    end
                    ST_DATA: begin
                        if (r_bit == 3'd7) begin
                            r_phase <= ST_STOP;
                            r_tx    <= 1'b1;
                            r_bit   <= '0;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end
                    default: begin
                        // end of stop bit with no follow-on byte
                        r_phase <= ST_IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end else begin
                r_baud <= r_baud + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hex_string_uart_tx.sv
// ---------------------------------------------------------------------------
// hex_string_uart_tx
// Latches one 8-character ASCII string per handshake and sends it as
// back-to-back 8N1 frames, optionally followed by CR LF.
//   i_clk, i_rst : clock, synchronous active-high reset
//   s_if         : slave side of the string handshake
//   o_tx         : UART line, idle high, registered
//   o_busy       : frames in progress
//   o_done       : one-cycle pulse after the final stop bit
// ---------------------------------------------------------------------------
module hex_string_uart_tx
    import hex_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int APPEND_CRLF  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    hex_string_uart_tx_if.slave  s_if,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done
);

    generate
        if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
            $error("hex_string_uart_tx: CLKS_PER_BIT must be in 2..65535");
        end
    endgenerate

    localparam logic [3:0] LAST_IDX = (APPEND_CRLF != 0) ? 4'd9 : 4'd7;

    logic [63:0]     r_hold;
    logic [3:0]      r_char_idx;
    logic            r_finish;

    hex_uart_state_e w_phase;
    hex_uart_state_e w_state;
    logic            w_accept;
    logic            w_last;
    logic            w_byte_done;
    logic            w_byte_start;
    logic [3:0]      w_next_idx;
    logic [7:0]      w_byte_data;

    // FINISH is the one cycle after the last stop bit; otherwise the state
    // is whatever phase the serializer is in.
    assign w_state        = r_finish ? ST_FINISH : w_phase;
    assign s_if.str_ready = (w_state == ST_IDLE);
    assign o_busy         = (w_phase != ST_IDLE);
    assign o_done         = r_finish;

    assign w_accept     = s_if.str_valid && s_if.str_ready;
    assign w_last       = (r_char_idx == LAST_IDX);
    assign w_next_idx   = r_char_idx + 4'd1;
    assign w_byte_start = w_accept || (w_byte_done && !w_last);
    // On the accept edge the holding register is not loaded yet, so char0
    // comes straight from the bus.
    assign w_byte_data  = w_accept ? s_if.str_in[63:56]
                                   : pick_char(r_hold, w_next_idx);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold     <= '0;
            r_char_idx <= '0;
            r_finish   <= 1'b0;
        end else begin
            r_finish <= w_byte_done && w_last;
            if (w_accept) begin
                r_hold     <= s_if.str_in;
                r_char_idx <= '0;
            end else if (w_byte_done && !w_last) begin
                r_char_idx <= w_next_idx;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (w_byte_start),
        .i_data      (w_byte_data),
        .o_tx        (o_tx),
        .o_byte_done (w_byte_done),
        .o_phase     (w_phase)
    );

endmodule

// File: doc/hex_string_uart_tx.md
Name: hex_string_uart_tx

Overview:
- Downstream consumer of the 32-bit-to-ASCII-hex converter in the password-cracking design.
- Accepts one 8-character ASCII hex string (64 bits) per handshake.
- Transmits the string on a UART line as 8N1 frames, optionally followed by CR LF, so the cracked password or the current candidate can be read on a host terminal.
- Latches the string at the handshake, so the upstream converter and the candidate counter may keep changing while transmission is in progress.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200). Legal range 2..65535; elaboration error outside this range.
- APPEND_CRLF, 1, when 1 send 0x0D then 0x0A after the 8 characters; when 0 send only the 8 characters.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- str_in  in  64  ASCII string. Char0 (sent first) is [63:56]; char7 is [7:0].
- str_valid  in  1  str_in is valid. Held high by the source until accepted.
- str_ready  out  1  block is idle and can accept. Equal to (state == IDLE).
- tx  out  1  UART serial output, idle high, registered.
- busy  out  1  high from the cycle after acceptance until the final stop bit ends.
- done  out  1  one-cycle pulse when the whole message has been sent.

Behaviour:
- Reset values: state=IDLE, tx=1, busy=0, done=0, therefore str_ready=1. Character index and bit/baud counters are 0.
- Reset mid-operation: transmission aborts. On the cycle after rst, tx=1 and state is IDLE. No done pulse; the partial message is discarded.
- Handshake: acceptance occurs on the clock edge where str_valid && str_ready.
  - At that edge str_in is latched into a 64-bit holding register and char_idx is set to 0.
  - The next cycle is the first start-bit cycle (tx=0); str_ready=0 and busy=1.
- Latched data: later changes on str_in or str_valid are ignored until the block returns to IDLE.
- Message length: N = 10 when APPEND_CRLF=1, else N = 8. Character sequence: char0..char7, then 0x0D, 0x0A.
- Frame format: each frame is start bit 0, then data bits 0..7 (LSB first), then stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles.
- Frame spacing: frames are back-to-back with no idle gap. Frame time is 10*CLKS_PER_BIT cycles; message time is N*10*CLKS_PER_BIT cycles.
- FSM states: IDLE -> START -> DATA (8 bits) -> STOP.
  - From STOP, go to START if char_idx < N-1 (char_idx increments). Otherwise go to FINISH.
  - FINISH lasts one cycle: done=1, tx=1, busy=0, str_ready=0. Then return to IDLE.
- Timing from an acceptance edge at cycle 0:
  - tx frames occupy cycles 1 .. N*10*CLKS_PER_BIT.
  - done is high in cycle N*10*CLKS_PER_BIT+1.
  - str_ready is high from cycle N*10*CLKS_PER_BIT+2.
- Back-to-back messages: with str_valid held high, the next acceptance occurs at cycle N*10*CLKS_PER_BIT+2. Between messages tx is high for exactly 2 cycles (FINISH + IDLE).
- Counter widths:
  - Baud counter: $clog2(CLKS_PER_BIT) bits; it wraps to 0 at CLKS_PER_BIT-1.
  - Bit counter: 3 bits.
  - char_idx: 4 bits.
- Character content: values are not checked. Any byte is transmitted as-is.

Decomposition:
- Shared package hex_uart_pkg:
  - ASCII_CR=8'h0D and ASCII_LF=8'h0A.
  - FSM state enum: IDLE, START, DATA, STOP, FINISH.
  - UART_FRAME_BITS=10.
- Sub-module uart_tx_byte:
  - Single-byte 8N1 serializer with ports start, data[7:0], tx, byte_done.
  - Owns the baud counter and bit counter.
  - Must re-accept start in the same cycle it asserts byte_done, so frames stay gapless.
- Top level: handles the handshake, the holding register, character selection via char_idx, CR/LF insertion and done generation.

Test Plan:
- Reset: assert rst 3 cycles with str_valid=1 -> tx=1, str_ready=1, busy=0, done=0 during and after reset; no acceptance while rst=1.
- CLKS_PER_BIT=4, APPEND_CRLF=1, str_in=64'h4445414442454546 ("DEADBEEF"), accept at cycle 0 -> UART decoder sees 44 45 41 44 42 45 45 46 0D 0A; tx first low at cycle 1; done high only at cycle 401; str_ready back at 402.
- APPEND_CRLF=0, str_in=64'h3030303030303041 ("0000000A") -> 8 bytes 30×7 then 41; done at cycle 321; no 0D/0A bytes.
- Back-to-back: str_valid held high and str_in switched to 64'h3132333435363738 at done -> second message accepted at cycle 402; tx high exactly in cycles 401-402; decoder sees "12345678" then CR LF.
- Data isolation: toggle str_in every cycle during a transmission -> transmitted bytes equal the value latched at acceptance.
- Reset mid-frame: assert rst during bit 3 of char2 -> tx=1 the following cycle, no done pulse, str_ready=1; the next message transmits correctly from char0.
